// File: rtl/stopwatch_counter.sv
// Minutes:seconds BCD stopwatch stage. Divided 1 Hz / 2 Hz clocks are edge-detected
// as data and drive run-mode counting or adjust-mode field increments on master_clock.
module stopwatch_counter #(
    parameter int MINUTE_MAX = 59
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       one_hz_in,
    input  logic       two_hz_in,
    input  logic       pause_pulse,
    input  logic       adjust,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       tick
);

    localparam logic [3:0] MIN_T_MAX = 4'(MINUTE_MAX / 10);
    localparam logic [3:0] MIN_O_MAX = 4'(MINUTE_MAX % 10);

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_PAUSED = 2'd1,
        MODE_ADJUST = 2'd2
    } mode_t;

    logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
    logic       r_paused, r_tick, r_prev_one, r_prev_two;

    logic [3:0] w_min_t_nxt, w_min_o_nxt, w_sec_t_nxt, w_sec_o_nxt;
    logic       w_one_edge, w_two_edge, w_tick_nxt, w_paused_nxt;
    logic [8:0] w_sec_inc, w_min_inc;
    mode_t      w_mode;

    // Two-digit BCD increment: {wrap_carry, tens, ones}; the field wraps to 00 past its max.
    function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] max_t, input logic [3:0] max_o);
        if (t == max_t && o == max_o)
            return 9'h100;
        else if (o >= 4'd9)
            return {1'b0, 4'(t + 4'd1), 4'd0};
        else
            return {1'b0, t, 4'(o + 4'd1)};
    endfunction

    assign w_one_edge = one_hz_in & ~r_prev_one;
    assign w_two_edge = two_hz_in & ~r_prev_two;
    assign w_sec_inc  = bcd_inc(r_sec_t, r_sec_o, 4'd5, 4'd9);
    assign w_min_inc  = bcd_inc(r_min_t, r_min_o, MIN_T_MAX, MIN_O_MAX);

    // Mode uses the pre-toggle paused flag so a simultaneous pause_pulse acts next cycle.
    always_comb begin
        w_mode = MODE_RUN;
        if (adjust)
            w_mode = MODE_ADJUST;
        else if (r_paused)
            w_mode = MODE_PAUSED;
    end

    always_comb begin
        w_min_t_nxt = r_min_t;
        w_min_o_nxt = r_min_o;
        w_sec_t_nxt = r_sec_t;
        w_sec_o_nxt = r_sec_o;
        unique case (w_mode)
            MODE_ADJUST: begin
                if (w_two_edge) begin
                    if (sel)
                        {w_sec_t_nxt, w_sec_o_nxt} = w_sec_inc[7:0];
                    else
                        {w_min_t_nxt, w_min_o_nxt} = w_min_inc[7:0];
                end
            end
            MODE_RUN: begin
                if (w_one_edge) begin
                    {w_sec_t_nxt, w_sec_o_nxt} = w_sec_inc[7:0];
                    if (w_sec_inc[8])
                        {w_min_t_nxt, w_min_o_nxt} = w_min_inc[7:0];
                end
            end
            default: ;
        endcase
    end

    assign w_tick_nxt   = {w_min_t_nxt, w_min_o_nxt, w_sec_t_nxt, w_sec_o_nxt}
                       != {r_min_t, r_min_o, r_sec_t, r_sec_o};
    assign w_paused_nxt = r_paused ^ (pause_pulse & ~adjust);

    always_ff @(posedge master_clock or negedge reset) begin
        if (!reset) begin
            r_min_t    <= 4'd0;
            r_min_o    <= 4'd0;
            r_sec_t    <= 4'd0;
            r_sec_o    <= 4'd0;
            r_paused   <= 1'b0;
            r_tick     <= 1'b0;
            r_prev_one <= 1'b0;
            r_prev_two <= 1'b0;
        end else begin
            r_min_t    <= w_min_t_nxt;
            r_min_o    <= w_min_o_nxt;
            r_sec_t    <= w_sec_t_nxt;
            r_sec_o    <= w_sec_o_nxt;
            r_paused   <= w_paused_nxt;
            r_tick     <= w_tick_nxt;
            r_prev_one <= one_hz_in;
            r_prev_two <= two_hz_in;
        end
    end

    assign min_tens = r_min_t;
    assign min_ones = r_min_o;
    assign sec_tens = r_sec_t;
    assign sec_ones = r_sec_o;
    assign paused   = r_paused;
    assign tick     = r_tick;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random stimulus, checked every
// cycle against a minutes/seconds integer model of the stopwatch.
module tb_stopwatch_counter;

    localparam int MM = 59;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one = 1'b0, two = 1'b0, pp = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, tick;

    int n_tests = 0;
    int n_fail  = 0;

    int m_min = 0, m_sec = 0;
    bit m_paused = 0, m_tick = 0, m_prev_one = 0, m_prev_two = 0;

    stopwatch_counter #(.MINUTE_MAX(MM)) dut (
        .master_clock(clk),
        .reset       (reset),
        .one_hz_in   (one),
        .two_hz_in   (two),
        .pause_pulse (pp),
        .adjust      (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .paused      (paused),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_time(input string name, input int mm, input int ss, input int pz);
        chk({name, ".min_tens"}, min_tens, mm / 10);
        chk({name, ".min_ones"}, min_ones, mm % 10);
        chk({name, ".sec_tens"}, sec_tens, ss / 10);
        chk({name, ".sec_ones"}, sec_ones, ss % 10);
        chk({name, ".paused"}, paused, pz);
    endtask

    // Reference model: time as whole minutes and seconds.
    initial begin : model
        int  tot;
        bit  oe, te, chg;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_min = 0; m_sec = 0; m_paused = 0; m_tick = 0;
                m_prev_one = 0; m_prev_two = 0;
            end else begin
                oe  = one && !m_prev_one;
                te  = two && !m_prev_two;
                chg = 0;
                if (adj) begin
                    if (te) begin
                        if (sel) m_sec = (m_sec + 1) % 60;
                        else     m_min = (m_min + 1) % (MM + 1);
                        chg = 1;
                    end
                end else if (!m_paused && oe) begin
                    tot   = (m_min * 60 + m_sec + 1) % ((MM + 1) * 60);
                    m_min = tot / 60;
                    m_sec = tot % 60;
                    chg   = 1;
                end
                if (pp && !adj) m_paused = !m_paused;
                m_prev_one = one;
                m_prev_two = two;
                m_tick     = chg;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("cyc.min_tens", min_tens, m_min / 10);
                chk("cyc.min_ones", min_ones, m_min % 10);
                chk("cyc.sec_tens", sec_tens, m_sec / 10);
                chk("cyc.sec_ones", sec_ones, m_sec % 10);
                chk("cyc.paused", paused, m_paused);
                chk("cyc.tick", tick, m_tick);
            end
        end
    end

    task automatic pulse_one();
        @(negedge clk) one = 1'b1;
        @(negedge clk) one = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_two();
        @(negedge clk) two = 1'b1;
        @(negedge clk) two = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_pause();
        @(negedge clk) pp = 1'b1;
        @(negedge clk) pp = 1'b0;
    endtask

    task automatic set_time(input int mm, input int ss);
        int ns, nm;
        @(negedge clk);
        adj = 1'b1;
        sel = 1'b1;
        ns  = (ss - m_sec + 60) % 60;
        nm  = (mm - m_min + MM + 1) % (MM + 1);
        repeat (ns) pulse_two();
        sel = 1'b0;
        repeat (nm) pulse_two();
        @(negedge clk) adj = 1'b0;
    endtask

    task automatic pulse_one_with_pause();
        @(negedge clk) begin one = 1'b1; pp = 1'b1; end
        @(negedge clk) begin one = 1'b0; pp = 1'b0; end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_time("reset_hold", 0, 0, 0);
        chk("reset_hold.tick", tick, 0);
        reset = 1'b1;

        repeat (3) pulse_one();
        chk_time("three_edges", 0, 3, 0);

        set_time(0, 59);
        pulse_one();
        chk_time("sec_carry", 1, 0, 0);

        set_time(59, 59);
        pulse_one();
        chk_time("full_wrap", 0, 0, 0);

        set_time(0, 10);
        pulse_pause();
        repeat (5) pulse_one();
        chk_time("paused_hold", 0, 10, 1);
        pulse_pause();
        pulse_one();
        chk_time("resume", 0, 11, 0);

        set_time(7, 58);
        @(negedge clk) begin adj = 1'b1; sel = 1'b1; end
        repeat (3) begin
            pulse_two();
            pulse_one();
        end
        chk_time("adj_sec", 7, 1, 0);
        sel = 1'b0;
        pulse_two();
        chk_time("adj_min", 8, 1, 0);
        @(negedge clk) adj = 1'b0;

        set_time(0, 20);
        pulse_one_with_pause();
        chk_time("simul_run", 0, 21, 1);
        pulse_one_with_pause();
        chk_time("simul_paused", 0, 21, 0);

        set_time(12, 34);
        pulse_pause();
        @(negedge clk);
        chk_time("pre_reset", 12, 34, 1);
        #1 reset = 1'b0;
        #1 chk_time("async_reset", 0, 0, 0);
        chk("async_reset.tick", tick, 0);
        one = 1'b1;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk_time("high_at_release", 0, 1, 0);
        chk("high_at_release.tick", tick, 1);
        @(negedge clk) one = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) one = ~one;
            if ($urandom_range(0, 2) == 0) two = ~two;
            pp = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) sel = ~sel;
        end
        @(negedge clk) begin pp = 1'b0; adj = 1'b0; end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Minutes:seconds time-keeping stage that consumes the divided clocks from the clock divider and produces four BCD digits for the seven-segment display driver. It counts 00:00 to 59:59 in run mode, holds in pause, and in adjust mode increments the selected field at 2 Hz. Divided clocks are treated as data, edge-detected and used as single-cycle enables. All logic runs on the single master clock.

## Interface

- MINUTE_MAX, default 59: highest minute value; 59:59 wraps to 00:00.

- master_clock  in  1  system clock; all registers on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- one_hz_in  in  1  1 Hz square wave from the divider, synchronous to master_clock
- two_hz_in  in  1  2 Hz square wave from the divider, synchronous to master_clock
- pause_pulse  in  1  one-cycle pulse; toggles run/paused
- adjust  in  1  level; 1 = adjust mode
- sel  in  1  adjust target: 0 = minutes, 1 = seconds
- min_tens  out  4  BCD, 0..5
- min_ones  out  4  BCD, 0..9
- sec_tens  out  4  BCD, 0..5
- sec_ones  out  4  BCD, 0..9
- paused  out  1  1 = count held
- tick  out  1  one-cycle pulse, high the cycle the digits show a new value

## Operation

- Edge detect: prev_one and prev_two registers capture the inputs each cycle. one_edge = one_hz_in & ~prev_one. two_edge = two_hz_in & ~prev_two. No synchronizers; inputs are same-domain.
- Mode is derived from adjust and the paused flag:
  - ADJUST when adjust=1. Overrides paused.
  - PAUSED when adjust=0 and paused=1.
  - RUN when adjust=0 and paused=0.
- RUN, on one_edge: sec_ones+1.
  - 9 wraps to 0 and carries to sec_tens.
  - sec 59 wraps to 00 and carries to minutes.
  - Minutes ripple the same way.
  - MINUTE_MAX:59 becomes 00:00.
  - two_edge is ignored.
- PAUSED: digits hold. Both edges are ignored.
- ADJUST, on two_edge: the selected field (sel) increments by 1 through BCD.
  - 59 wraps to 00 with no carry into the other field.
  - one_edge is ignored.
  - pause_pulse is ignored; the paused flag is retained.
- pause_pulse with adjust=0 toggles the paused flag.
- Simultaneous events:
  - Mode is evaluated on pre-toggle state.
  - pause_pulse with one_edge in RUN: the increment is applied and paused becomes 1.
  - The same pair in PAUSED: no increment and paused becomes 0.
- adjust 1→0: returns to RUN or PAUSED per the retained flag. The next one_edge counts normally.
- sel change mid-adjust takes effect on the next two_edge.
- Digits never leave legal BCD ranges.

## Timing

- Reset (reset=0) values: all digits 0, paused=0, tick=0, prev_one=0, prev_two=0.
- After reset release, an input already high on the first clock counts as an edge.
- Latency: an input rising, sampled in cycle N, updates the digits and asserts tick in cycle N+1.
- Exactly one increment per input rising edge; a held-high input produces no further edges.
- paused updates the cycle after pause_pulse.
- tick is high for exactly one cycle per change, and only when the digit value actually changes.
- Reset asserted mid-operation clears outputs asynchronously, without waiting for a clock edge.

## Test plan

- Reset, then 3 one_hz_in rising edges: digits 00:03, 3 single-cycle tick pulses, each one cycle after its edge.
- Carry and wrap:
  - Adjust to 00:59, adjust=0, one edge: 01:00.
  - Adjust to 59:59, one edge: 00:00.
- Pause:
  - From 00:10, pause_pulse then 5 one_hz edges: stays 00:10, paused=1, no tick.
  - Second pause_pulse, then 1 edge: 00:11.
- Adjust seconds:
  - Setup: 07:58, adjust=1, sel=1.
  - 3 two_hz edges plus interleaved one_hz edges: 07:01, minutes untouched, one_hz ignored.
  - sel=0, 1 two_hz edge: 08:01.
- Simultaneous events:
  - In RUN at 00:20, pause_pulse in the same cycle as one_edge: 00:21, paused=1.
  - Repeat in PAUSED: stays 00:21, paused=0.
- Reset mid-operation: reset=0 at 12:34 between clock edges: outputs read 00:00 and paused=0 before the next master_clock edge.
